key_scan: RTL

//  Input-side counterpart of the LED column scanner: scans a 4x4 keypad on the iCEstick PMOD.

---
 rtl/key_scan.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_scan.sv
`timescale 1ns/1ps
// key_scan
// Scans a 4x4 keypad on the iCEstick PMOD. One column is driven low at a
// time; the four active-low rows are synchronised, sampled once per column
// slot and debounced per key. Debounced state is published as a bitmap, and
// each debounced change is queued as a press/release event in a small FIFO
// drained through a valid/ready handshake.
//
// Ports
//   clk12MHz     in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   col_n        out  4   column drive, one-hot active-low
//   rows_n       in   4   row sense, active-low, asynchronous to clk12MHz
//   keys         out  16  debounced state, bit k = row*4 + col, 1 = pressed
//   evt_valid    out  1   FIFO head holds an event
//   evt_ready    in   1   consumer accepts the head event
//   evt_code     out  4   key index of head event
//   evt_press    out  1   1 = press, 0 = release
//   overflow     out  1   sticky, at least one event was dropped
//   overflow_clr in   1   synchronous clear of overflow
module key_scan #(
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk12MHz,
  input  logic        reset,
  output logic [3:0]  col_n,
  input  logic [3:0]  rows_n,
  output logic [15:0] keys,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_code,
  output logic        evt_press,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam int unsigned      DIV_W     = $clog2(SCAN_DIV);
  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       CNT_LAST  = 3'(DEBOUNCE_SCANS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Row synchroniser (reset to released)
  // ---------------------------------------------------------------------------
  logic [3:0] rows_meta;
  logic [3:0] rows_s;

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      rows_meta <= '1;
      rows_s    <= '1;
    end else begin
      rows_meta <= rows_n;
      rows_s    <= rows_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot divider and column counter
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic             tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      div <= '0;
      col <= '0;
    end else if (tick) begin
      div <= '0;
      col <= col + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    col_n = ~(4'b0001 << col);
  end

  // ---------------------------------------------------------------------------
  // Debounce: the sample at the end of a slot still belongs to the column that
  // was driven for the whole slot, since col only advances after the tick.
  // ---------------------------------------------------------------------------
  logic [2:0]  cnt     [16];
  logic [2:0]  cnt_nxt [16];
  logic [15:0] keys_nxt;
  logic [3:0]  chg;
  logic [3:0]  k;
  logic        raw;

  always_comb begin
    keys_nxt = keys;
    cnt_nxt  = cnt;
    chg      = '0;
    k        = '0;
    raw      = 1'b0;
    if (tick) begin
      for (int unsigned r = 0; r < 4; r++) begin
        k   = {r[1:0], col};
        raw = ~rows_s[r];
        if (raw == keys[k]) begin
          cnt_nxt[k] = '0;
        end else if (cnt[k] == CNT_LAST) begin
          keys_nxt[k] = raw;
          cnt_nxt[k]  = '0;
          chg[r]      = 1'b1;
        end else begin
          cnt_nxt[k] = cnt[k] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      keys <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      keys <= keys_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Event serialiser: walks rows 0..3 on the four cycles after a tick and
  // pushes one event per flagged row. The column is captured alongside the
  // flags because col has already moved on by the time the rows are walked.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    SER_IDLE,
    SER_ROW0,
    SER_ROW1,
    SER_ROW2,
    SER_ROW3
  } ser_state_t;

  ser_state_t ser_state;
  ser_state_t ser_next;
  logic [3:0] ser_flags;
  logic [1:0] ser_col;
  logic [1:0] push_row;
  logic       push;
  logic [3:0] push_code;
  logic       push_press;

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      ser_state <= SER_IDLE;
      ser_flags <= '0;
      ser_col   <= '0;
    end else begin
      ser_state <= ser_next;
      if (tick) begin
        ser_flags <= chg;
        ser_col   <= col;
      end
    end
  end

  always_comb begin
    ser_next = ser_state;
    push_row = 2'd0;
    push     = 1'b0;
    case (ser_state)
      SER_ROW0: begin push_row = 2'd0; ser_next = SER_ROW1; end
      SER_ROW1: begin push_row = 2'd1; ser_next = SER_ROW2; end
      SER_ROW2: begin push_row = 2'd2; ser_next = SER_ROW3; end
      SER_ROW3: begin push_row = 2'd3; ser_next = SER_IDLE; end
      default:  ser_next = SER_IDLE;
    endcase
    if (ser_state != SER_IDLE) begin
      push = ser_flags[push_row];
    end
    // SCAN_DIV >= 8 keeps a new tick clear of the four-cycle walk.
    if (tick) begin
      ser_next = SER_ROW0;
    end
  end

  assign push_code  = {push_row, ser_col};
  assign push_press = keys[push_code];

  // ---------------------------------------------------------------------------
  // Event FIFO (registered storage, head read straight from the array)
  // ---------------------------------------------------------------------------
  logic [3:0]       fifo_code  [FIFO_DEPTH];
  logic             fifo_press [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign full      = (count == FIFO_FULL);
  assign evt_valid = (count != '0);
  assign do_pop    = evt_valid & evt_ready;
  // A full FIFO drops the push even if a pop frees a slot the same cycle.
  assign do_push   = push & ~full;
  assign drop      = push & full;
  assign evt_code  = fifo_code[rd_ptr];
  assign evt_press = fifo_press[rd_ptr];

  always_ff @(posedge clk12MHz) begin
    if (do_push) begin
      fifo_code[wr_ptr]  <= push_code;
      fifo_press[wr_ptr] <= push_press;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
